// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage register with valid/ready handshake,
// flush-to-NOP, optional 2-entry skid buffer and stall counter.
module pipe_stage_elastic #(
  parameter int                DATA_W    = 96,
  parameter bit                SKID      = 1'b1,
  parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{1'b0}},
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]        occ_q;
  logic [1:0]        occ_n;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_n;
  logic [DATA_W-1:0] skid_q;
  logic [DATA_W-1:0] skid_n;
  logic              rdy_q;
  logic [CNT_W-1:0]  stall_q;
  logic              accept;
  logic              xfer;

  assign out_valid    = (occ_q != EMPTY);
  assign out_data     = data_q;
  assign occupancy    = occ_q;
  assign stall_cycles = stall_q;

  // Skid mode: ready comes from a flop, never from out_ready.
  assign in_ready = SKID ? rdy_q
                         : (~out_valid | out_ready);

  assign accept = in_valid & in_ready & ~flush;
  assign xfer   = out_valid & out_ready;

  // Next-state decode of occupancy, head and skid entries.
  always_comb begin
    occ_n  = occ_q;
    data_n = data_q;
    skid_n = skid_q;
    if (flush) begin
      occ_n  = EMPTY;
      data_n = NOP_VALUE;
    end else begin
      unique case (1'b1)
        (occ_q == EMPTY): begin
          if (accept) begin
            occ_n  = ONE;
            data_n = in_data;
          end
        end
        (occ_q == ONE): begin
          if (accept && xfer) begin
            data_n = in_data;
          end else if (accept) begin
            if (SKID) begin
              occ_n  = FULL;
              skid_n = in_data;
            end
          end else if (xfer) begin
            occ_n  = EMPTY;
            data_n = NOP_VALUE;
          end
        end
        (occ_q == FULL): begin
          if (xfer) begin
            occ_n  = ONE;
            data_n = skid_q;
          end
        end
        default: begin
          occ_n  = EMPTY;
          data_n = NOP_VALUE;
        end
      endcase
    end
  end

  // Stage state updates on the falling edge.
  always_ff @(negedge clk) begin
    if (rst) begin
      occ_q  <= EMPTY;
      data_q <= NOP_VALUE;
      skid_q <= NOP_VALUE;
      rdy_q  <= 1'b1;
    end else begin
      occ_q  <= occ_n;
      data_q <= data_n;
      skid_q <= skid_n;
      rdy_q  <= (occ_n != FULL);
    end
  end

  // Saturating count of edges where downstream holds us off.
  always_ff @(negedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (out_valid && !out_ready
                 && stall_q != {CNT_W{1'b1}}) begin
      stall_q <= stall_q + 1'b1;
    end
  end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised elastic pipeline stage register; successor to the fixed-width inter-stage latch.
- Sits between any two pipeline stages (IF/ID, ID/EX, ...). Carries a DATA_W-bit bundle with valid/ready handshake, flush-to-NOP and an optional 2-entry skid buffer so back-pressure does not depend on a combinational ready path.
- Saturating stall-cycle counter for performance debug.

Parameters:
- DATA_W, 96, width of the carried bundle (e.g. instruction + pc + pc+4).
- SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single entry with combinational ready pass-through.
- NOP_VALUE, {DATA_W{1'b0}}, value driven on out_data when empty or flushed.
- CNT_W, 16, stall counter width.

Ports:
- clk, input, 1, clock; all state updates on falling edge of clk (codebase pipeline phase).
- rst, input, 1, synchronous, active-high reset, sampled on falling edge of clk.
- flush, input, 1, squash all held and incoming data (branch taken / NextPCSrc).
- in_valid, input, 1, upstream has data.
- in_data, input, DATA_W, upstream bundle.
- in_ready, output, 1, stage can accept this cycle.
- out_valid, output, 1, out_data is valid.
- out_data, output, DATA_W, registered bundle to downstream.
- out_ready, input, 1, downstream accepts (0 = hazard stall).
- occupancy, output, 2, entries held (0..2; max 1 when SKID=0).
- stall_cycles, output, CNT_W, saturating count of cycles with out_valid=1 and out_ready=0.

Behaviour:
- Priority on each falling edge: rst > flush > handshake.
- Reset values: out_valid=0, out_data=NOP_VALUE, skid entry empty, occupancy=0, stall_cycles=0. in_ready=1 in the cycle after reset.
- Handshakes:
  - Input accept when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - Data not accepted is never lost or duplicated; order is preserved.
- SKID=1 states (by occupancy):
  - EMPTY (0): in_ready=1. Accept moves to ONE, with out_data<=in_data.
  - ONE (1): in_ready=1.
    - Accept & transfer: out_data<=in_data, stay ONE.
    - Accept & no transfer: in_data goes to skid, move to FULL.
    - Transfer only: move to EMPTY, out_data<=NOP_VALUE.
  - FULL (2): in_ready=0, driven from a register with no combinational path from out_ready. Transfer: out_data<=skid, move to ONE.
- SKID=0:
  - in_ready = ~out_valid | out_ready (combinational).
  - Accept loads out_data. Transfer without accept empties the stage and loads NOP_VALUE.
- Flush:
  - All entries are cleared, out_valid=0, out_data=NOP_VALUE, occupancy=0 on that edge.
  - An input accepted on the same edge is discarded.
  - in_valid is ignored during a flush cycle.
- out_data holds stable while out_valid=1 & out_ready=0.
- stall_cycles increments by 1 per stalled edge and saturates at 2^CNT_W-1. Only rst clears it; flush does not.
- Reset mid-operation discards all contents with no transfer on that edge.

Test Plan:
- Reset then stream: rst pulse, out_ready=1, push 0x..01, 0x..02, 0x..03 back-to-back -> each appears on out_data 1 edge after accept, out_valid continuous, occupancy stays 1, stall_cycles=0.
- Back-pressure (SKID=1): ONE holding A; out_ready=0, push B -> FULL, in_ready=0 next cycle, out_data=A, stall_cycles increments each edge. out_ready=1 -> A then B delivered in order, no loss.
- Flush with full skid: occupancy=2, assert flush with in_valid=1, data C -> next edge out_valid=0, out_data=NOP_VALUE, occupancy=0; C never appears on output.
- rst vs flush: rst and flush both high while holding data -> reset values on all outputs, including stall_cycles=0.
- SKID=0 ready path: out_valid=1, out_ready toggled 0->1 in the same cycle as in_valid=1 -> in_ready follows out_ready combinationally; new data is loaded on that edge.
- Counter saturation (CNT_W=4): hold out_ready=0 with valid data for 20 edges -> stall_cycles=15 and it stays at 15.
